// File: rtl/app_output_mux_if.sv
// Channel-side FWFT read ports and output_fifo write port of app_output_mux.
// The mux side is the master modport; the FIFOs / bench sit on the slave side.
interface app_output_mux_if #(
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [N_CHANNELS*DATA_WIDTH-1:0] ch_dout;
  logic [N_CHANNELS-1:0]            ch_last;
  logic [N_CHANNELS-1:0]            ch_empty;
  logic [N_CHANNELS-1:0]            ch_rd_en;
  logic [N_CHANNELS-1:0]            ch_enable;
  logic [DATA_WIDTH-1:0]            dout;
  logic                             wr_en;
  logic                             full;

  modport master (
    input  ch_dout, ch_last, ch_empty, ch_enable, full,
    output ch_rd_en, dout, wr_en
  );

  modport slave (
    output ch_dout, ch_last, ch_empty, ch_enable, full,
    input  ch_rd_en, dout, wr_en
  );
endinterface

// File: rtl/app_output_mux.sv
// N-channel packet-granular round-robin merge into the 16-bit output FIFO, with output-limit accounting.
// Optional packet-length watchdog: define APP_OUTPUT_MUX_WATCHDOG_EN.
module app_output_mux #(
  parameter int unsigned N_CHANNELS    = 4,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned LIMIT_WIDTH   = 16,
  parameter int unsigned MAX_PKT_WORDS = 4096
) (
  input  logic                   CLK,
  input  logic                   RESET,
  app_output_mux_if.master       bus,
  input  logic                   mode_limit,
  input  logic                   reg_output_limit,
  output logic [LIMIT_WIDTH-1:0] output_limit,
  output logic                   output_limit_not_done,
  output logic [3:0]             cur_channel,
  output logic                   err_pkt_len
);
  localparam int unsigned SEL_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  if (N_CHANNELS < 1 || N_CHANNELS > 16 || MAX_PKT_WORDS < 1) begin : g_param_check
    $error("app_output_mux: unsupported parameter values");
  end

  typedef enum logic {ARB, XFER} state_t;

  state_t                 state, state_n;
  logic [3:0]             ptr, ptr_n, grant_n;
  logic [SEL_W-1:0]       g;
  logic                   xfer;
  logic                   found;
  logic [LIMIT_WIDTH-1:0] word_cnt;

`ifdef APP_OUTPUT_MUX_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(MAX_PKT_WORDS + 1);
  logic [WD_W-1:0] wd_cnt, wd_n;
  logic            err_n;
`endif

  assign g    = SEL_W'(cur_channel);
  // RESET gates the pass-through so an abandoned packet loses no word.
  assign xfer = (state == XFER) && !bus.ch_empty[g] && !bus.full && !RESET;

  always_comb begin
    int unsigned idx;
    state_n      = state;
    grant_n      = cur_channel;
    ptr_n        = ptr;
    found        = 1'b0;
    idx          = 0;
    bus.wr_en    = xfer;
    bus.ch_rd_en = N_CHANNELS'(xfer) << g;
    bus.dout     = bus.ch_dout[g*DATA_WIDTH +: DATA_WIDTH];
`ifdef APP_OUTPUT_MUX_WATCHDOG_EN
    wd_n  = wd_cnt;
    err_n = err_pkt_len;
`endif
    case (state)
      ARB: begin
        for (int unsigned k = 0; k < N_CHANNELS; k++) begin
          idx = 32'(ptr) + k;
          if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
          if (!found && bus.ch_enable[SEL_W'(idx)] && !bus.ch_empty[SEL_W'(idx)]) begin
            found   = 1'b1;
            grant_n = 4'(idx);
          end
        end
        if (found) state_n = XFER;
`ifdef APP_OUTPUT_MUX_WATCHDOG_EN
        wd_n = '0;
`endif
      end
      XFER: begin
        if (xfer) begin
          if (bus.ch_last[g]) begin
            state_n = ARB;
            ptr_n   = (32'(cur_channel) == N_CHANNELS - 1) ? 4'd0 : cur_channel + 4'd1;
          end
`ifdef APP_OUTPUT_MUX_WATCHDOG_EN
          else if (wd_cnt == WD_W'(MAX_PKT_WORDS - 1)) begin
            err_n   = 1'b1;
            state_n = ARB;
            ptr_n   = (32'(cur_channel) == N_CHANNELS - 1) ? 4'd0 : cur_channel + 4'd1;
          end else begin
            wd_n = wd_cnt + WD_W'(1);
          end
`endif
        end
      end
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ARB;
      cur_channel <= 4'd0;
      ptr         <= 4'd0;
    end else begin
      state       <= state_n;
      cur_channel <= grant_n;
      ptr         <= ptr_n;
    end
  end

`ifdef APP_OUTPUT_MUX_WATCHDOG_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wd_cnt      <= '0;
      err_pkt_len <= 1'b0;
    end else begin
      wd_cnt      <= wd_n;
      err_pkt_len <= err_n;
    end
  end
`else
  assign err_pkt_len = 1'b0;
`endif

  // Saturating word counter; a write coinciding with the latch pulse opens the new interval.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      word_cnt              <= '0;
      output_limit          <= '0;
      output_limit_not_done <= 1'b0;
    end else if (!mode_limit) begin
      word_cnt <= '0;
      if (reg_output_limit) begin
        output_limit          <= '0;
        output_limit_not_done <= 1'b0;
      end
    end else if (reg_output_limit) begin
      output_limit          <= word_cnt;
      output_limit_not_done <= &word_cnt;
      word_cnt              <= LIMIT_WIDTH'(bus.wr_en);
    end else if (bus.wr_en && !(&word_cnt)) begin
      word_cnt <= word_cnt + LIMIT_WIDTH'(1);
    end
  end
endmodule

// File: doc/app_output_mux.md
Name: app_output_mux

Overview:
- Parametrised N-channel successor to the single-application output path.
- Merges packet streams from N application cores into the one 16-bit output FIFO feeding the high-speed interface.
- Packets from different channels never interleave; channels are served round-robin at packet granularity.
- Maintains the output-limit word accounting (mode_limit / reg_output_limit / output_limit / output_limit_not_done) consumed by the VCR block.
- Sits in the PKT_COMM_CLK domain, between per-core FWFT output FIFOs and output_fifo's write port.

Parameters:
N_CHANNELS, 4, number of input channels (1..16)
DATA_WIDTH, 16, word width of every channel and the output
LIMIT_WIDTH, 16, width of output word counter and output_limit
MAX_PKT_WORDS, 4096, packet length bound used by the optional watchdog

Ports:
CLK  in  1  PKT_COMM_CLK domain clock
RESET  in  1  synchronous, active-high reset
ch_dout  in  N_CHANNELS*DATA_WIDTH  channel words, FWFT; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
ch_last  in  N_CHANNELS  last-word-of-packet flag accompanying ch_dout
ch_empty  in  N_CHANNELS  channel FIFO empty
ch_rd_en  out  N_CHANNELS  channel pop, one-hot or zero
ch_enable  in  N_CHANNELS  arbitration mask (from app_mode)
dout  out  DATA_WIDTH  word to output_fifo
wr_en  out  1  output_fifo write strobe
full  in  1  output_fifo full
mode_limit  in  1  1 = limit accounting active
reg_output_limit  in  1  one-cycle pulse: latch word count into output_limit
output_limit  out  LIMIT_WIDTH  latched word count
output_limit_not_done  out  1  counter saturated at latch time
cur_channel  out  4  channel currently granted
err_pkt_len  out  1  sticky watchdog error (0 when feature absent)

Behaviour:
- Reset state: ch_rd_en=0, wr_en=0, output_limit=0, output_limit_not_done=0, cur_channel=0, err_pkt_len=0; FSM in ARB; round-robin pointer at 0; word counter 0.
- RESET asserted mid-packet: in that cycle ch_rd_en=0 and wr_en=0; the partial packet is abandoned; remaining words stay in the channel FIFO.
- State ARB:
  - Search starts at (last granted + 1) mod N_CHANNELS.
  - First channel with ch_enable=1 and ch_empty=0 is granted.
  - cur_channel <= that index; next state XFER; no data moves in this cycle.
  - No eligible channel: remain in ARB.
- State XFER:
  - xfer = !ch_empty[g] && !full, combinational.
  - ch_rd_en[g] = wr_en = xfer; dout = ch_dout[g], combinational; zero-latency FWFT pass-through.
  - xfer with ch_last[g]=1: next state ARB; the pointer advances past g.
  - Channel empty mid-packet: wait in XFER; the grant is held and no other channel is served.
- Clearing ch_enable[g] mid-packet does not abort; the packet completes, then the channel is skipped.
- full=1: no pop and no write. full going low resumes in the same cycle.
- Single-word packet (ch_last on first word): one XFER cycle, then ARB. Per-channel throughput = packet words + 1 arbitration cycle.
- Word counter (LIMIT_WIDTH bits):
  - mode_limit=1: increments on each wr_en; saturates at all-ones, never wraps.
  - mode_limit=0: held at 0.
- reg_output_limit pulse:
  - output_limit <= counter value; output_limit_not_done <= (counter == all-ones).
  - Counter restarts from 0. A write in the same cycle counts toward the new interval (counter <= 1).
  - With mode_limit=0: output_limit <= 0, output_limit_not_done <= 0.

Optional Feature:
- Macro: APP_OUTPUT_MUX_WATCHDOG_EN.
- Defined:
  - A per-grant word counter runs in XFER and counts popped words.
  - If MAX_PKT_WORDS words are popped without ch_last, err_pkt_len is set (sticky until RESET) and the FSM returns to ARB, releasing the grant.
- Undefined:
  - No length counter; err_pkt_len is tied to 0.
  - A packet lacking ch_last holds the grant indefinitely.

Test Plan:
- Reset, then all four channels each holding a 3-word packet, all enabled -> output order ch0,ch1,ch2,ch3; 12 wr_en pulses; 4 ARB gap cycles; cur_channel sequence 0,1,2,3.
- ch1 packet of 5 words with full asserted for cycles 2-4 of transfer -> no ch_rd_en/wr_en during full; all 5 words delivered in order; no other channel interleaved.
- ch_enable=4'b0101, all channels non-empty -> only ch0 and ch2 served, alternating; clear ch_enable[2] mid-packet -> current ch2 packet completes, then only ch0 is served.
- mode_limit=1, 10 words written, then reg_output_limit pulse coincident with the 11th write -> output_limit=10, not_done=0, counter=1; with LIMIT_WIDTH=4 and 20 writes -> output_limit=15, not_done=1.
- RESET asserted on the 2nd word of a 4-word ch3 packet -> wr_en=0 that cycle; all outputs return to reset values; next grant after reset is ch0.
- With APP_OUTPUT_MUX_WATCHDOG_EN and MAX_PKT_WORDS=8, ch0 streams 8 words without ch_last -> err_pkt_len=1 after the 8th pop; ch1 is granted next; without the macro -> ch0 keeps the grant and err_pkt_len stays 0.
